hazard_unit: RTL and testbench



---
 rtl/hazard_unit_pkg.sv | 6 +
 rtl/hazard_unit_if.sv | 32 +++
 rtl/hazard_unit_reg_match.sv | 12 +
 rtl/hazard_unit.sv | 59 +++++
 tb/tb_hazard_unit.sv | 132 +++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared FSM encoding and register constants for the hazard unit.
package hazard_unit_pkg;
  localparam logic [0:0] HZ_RUN      = 1'b0;
  localparam logic [0:0] HZ_MEM_WAIT = 1'b1;
  localparam logic [4:0] REG_ZERO    = 5'd0;
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline-to-hazard-unit signal bundle; perf counters exist only with HAZARD_PERF_EN.
interface hazard_unit_if #(parameter int CNT_W = 32);
  logic [4:0] rs_addr, rt_addr;
  logic       id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken;
  logic       id_ex_MemRead, id_ex_RegWrite;
  logic [4:0] id_ex_write_addr;
  logic       ex_mem_MemRead;
  logic [4:0] ex_mem_write_addr;
  logic       mem_busy;
  logic       stall_pc, stall_if_id, bubble_id_ex, flush_if_id;
  logic       stall_id_ex, stall_ex_mem, bubble_mem_wb;
  logic       in_mem_wait;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_load_stalls, perf_branch_stalls, perf_mem_wait;
`endif
  modport master (
    output rs_addr, rt_addr, id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken,
    output id_ex_MemRead, id_ex_RegWrite, id_ex_write_addr, ex_mem_MemRead, ex_mem_write_addr, mem_busy,
    input stall_pc, stall_if_id, bubble_id_ex, flush_if_id, stall_id_ex, stall_ex_mem, bubble_mem_wb, in_mem_wait
`ifdef HAZARD_PERF_EN
    , input perf_load_stalls, perf_branch_stalls, perf_mem_wait
`endif
  );
  modport slave (
    input rs_addr, rt_addr, id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken,
    input id_ex_MemRead, id_ex_RegWrite, id_ex_write_addr, ex_mem_MemRead, ex_mem_write_addr, mem_busy,
    output stall_pc, stall_if_id, bubble_id_ex, flush_if_id, stall_id_ex, stall_ex_mem, bubble_mem_wb, in_mem_wait
`ifdef HAZARD_PERF_EN
    , output perf_load_stalls, perf_branch_stalls, perf_mem_wait
`endif
  );
endinterface

// File: rtl/hazard_unit_reg_match.sv
// reg_match: source register hits a valid, nonzero destination.
module reg_match
  import hazard_unit_pkg::*;
(
  input  logic [4:0] i_addr,
  input  logic       i_uses,
  input  logic [4:0] i_dest,
  input  logic       i_dest_valid,
  output logic       o_hit
);
  assign o_hit = i_uses && i_dest_valid && (i_addr != REG_ZERO) && (i_addr == i_dest);
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: MIPS stall/flush controller (load-use, branch operand, memory wait, deferred flush).
// Optional event counters enabled by defining HAZARD_PERF_EN.
module hazard_unit
  import hazard_unit_pkg::*;
(
  input logic        clk,
  input logic        reset,
  hazard_unit_if.slave hz
);
  logic w_rs_ld, w_rt_ld, w_rs_alu, w_rt_alu, w_rs_mem, w_rt_mem;
  logic w_alu_valid, w_lu, w_br, w_hz, w_frz;
  logic [0:0] r_state;
  logic r_pend_flush;
  assign w_alu_valid = hz.id_ex_RegWrite & ~hz.id_ex_MemRead;
  reg_match u_rs_ld  (.i_addr(hz.rs_addr), .i_uses(hz.id_uses_rs), .i_dest(hz.id_ex_write_addr),  .i_dest_valid(hz.id_ex_MemRead),  .o_hit(w_rs_ld));
  reg_match u_rt_ld  (.i_addr(hz.rt_addr), .i_uses(hz.id_uses_rt), .i_dest(hz.id_ex_write_addr),  .i_dest_valid(hz.id_ex_MemRead),  .o_hit(w_rt_ld));
  reg_match u_rs_alu (.i_addr(hz.rs_addr), .i_uses(hz.id_uses_rs), .i_dest(hz.id_ex_write_addr),  .i_dest_valid(w_alu_valid),       .o_hit(w_rs_alu));
  reg_match u_rt_alu (.i_addr(hz.rt_addr), .i_uses(hz.id_uses_rt), .i_dest(hz.id_ex_write_addr),  .i_dest_valid(w_alu_valid),       .o_hit(w_rt_alu));
  reg_match u_rs_mem (.i_addr(hz.rs_addr), .i_uses(hz.id_uses_rs), .i_dest(hz.ex_mem_write_addr), .i_dest_valid(hz.ex_mem_MemRead), .o_hit(w_rs_mem));
  reg_match u_rt_mem (.i_addr(hz.rt_addr), .i_uses(hz.id_uses_rt), .i_dest(hz.ex_mem_write_addr), .i_dest_valid(hz.ex_mem_MemRead), .o_hit(w_rt_mem));
  // BR2 (branch after load) stalls here, then reappears as BRM next cycle
  assign w_lu  = w_rs_ld | w_rt_ld;
  assign w_br  = hz.id_is_branch & (w_lu | w_rs_alu | w_rt_alu | w_rs_mem | w_rt_mem);
  assign w_hz  = w_lu | w_br;
  assign w_frz = hz.mem_busy;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state      <= HZ_RUN;
      r_pend_flush <= 1'b0;
    end else begin
      r_state      <= w_frz ? HZ_MEM_WAIT : HZ_RUN;
      r_pend_flush <= w_frz ? (r_pend_flush | hz.id_branch_taken) : (w_hz & r_pend_flush);
    end
  assign hz.stall_pc      = reset & (w_frz | w_hz);
  assign hz.stall_if_id   = reset & (w_frz | w_hz);
  assign hz.bubble_id_ex  = reset & ~w_frz & w_hz;
  assign hz.flush_if_id   = reset & ~w_frz & ~w_hz & (hz.id_branch_taken | r_pend_flush);
  assign hz.stall_id_ex   = reset & w_frz;
  assign hz.stall_ex_mem  = reset & w_frz;
  assign hz.bubble_mem_wb = reset & w_frz;
  assign hz.in_mem_wait   = r_state == HZ_MEM_WAIT;
`ifdef HAZARD_PERF_EN
  localparam int CW = $bits(hz.perf_load_stalls);
  logic [CW-1:0] r_ld_cnt, r_br_cnt, r_mw_cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ld_cnt <= '0;
      r_br_cnt <= '0;
      r_mw_cnt <= '0;
    end else begin
      if (!w_frz && w_lu && !(&r_ld_cnt)) r_ld_cnt <= r_ld_cnt + CW'(1);
      if (!w_frz && w_br && !(&r_br_cnt)) r_br_cnt <= r_br_cnt + CW'(1);
      if (w_frz && !(&r_mw_cnt)) r_mw_cnt <= r_mw_cnt + CW'(1);
    end
  assign hz.perf_load_stalls   = r_ld_cnt;
  assign hz.perf_branch_stalls = r_br_cnt;
  assign hz.perf_mem_wait      = r_mw_cnt;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed plus random stimulus, reference model feeds a scoreboard checked by a monitor.
module tb_hazard_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  hazard_unit_if hz();
  hazard_unit dut (.clk(clk), .reset(reset), .hz(hz));
  typedef struct packed {
    logic [4:0] rs, rt;
    logic urs, urt, br, tk, exr, exw;
    logic [4:0] exd;
    logic mr;
    logic [4:0] md;
    logic busy;
  } stim_t;
  typedef struct {
    logic [6:0] o;
    longint ld, bc, mw;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit pend = 0, n_pend = 0;
  longint m_ld = 0, m_bc = 0, m_mw = 0, n_ld = 0, n_bc = 0, n_mw = 0;
  function automatic bit hit(logic [4:0] a, logic u, logic [4:0] d);
    return u && a != 5'd0 && a == d;
  endfunction
  task automatic step(input stim_t s, input logic rn);
    exp_t e;
    bit exh, memh, lu, br;
    @(posedge clk);
    pend = n_pend; m_ld = n_ld; m_bc = n_bc; m_mw = n_mw;
    #1;
    reset = rn;
    hz.rs_addr = s.rs; hz.rt_addr = s.rt; hz.id_uses_rs = s.urs; hz.id_uses_rt = s.urt;
    hz.id_is_branch = s.br; hz.id_branch_taken = s.tk;
    hz.id_ex_MemRead = s.exr; hz.id_ex_RegWrite = s.exw; hz.id_ex_write_addr = s.exd;
    hz.ex_mem_MemRead = s.mr; hz.ex_mem_write_addr = s.md; hz.mem_busy = s.busy;
    exh  = hit(s.rs, s.urs, s.exd) || hit(s.rt, s.urt, s.exd);
    memh = hit(s.rs, s.urs, s.md) || hit(s.rt, s.urt, s.md);
    lu = s.exr && exh;
    br = s.br && (((s.exr || s.exw) && exh) || (s.mr && memh));
    if (!rn) begin
      pend = 0; m_ld = 0; m_bc = 0; m_mw = 0;
      e.o = 7'b0;
      n_pend = 0; n_ld = 0; n_bc = 0; n_mw = 0;
    end else if (s.busy) begin
      e.o = 7'b1100111;
      n_pend = pend || s.tk; n_ld = m_ld; n_bc = m_bc; n_mw = m_mw + 1;
    end else if (lu || br) begin
      e.o = 7'b1110000;
      n_pend = pend; n_ld = m_ld + (lu ? 1 : 0); n_bc = m_bc + (br ? 1 : 0); n_mw = m_mw;
    end else begin
      e.o = {3'b000, s.tk || pend, 3'b000};
      n_pend = 0; n_ld = m_ld; n_bc = m_bc; n_mw = m_mw;
    end
    e.ld = m_ld; e.bc = m_bc; e.mw = m_mw;
    q.push_back(e);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [6:0] a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {hz.stall_pc, hz.stall_if_id, hz.bubble_id_ex, hz.flush_if_id, hz.stall_id_ex, hz.stall_ex_mem, hz.bubble_mem_wb};
      checks++;
      if (a !== e.o) begin
        errors++;
        $display("FAIL ctl t=%0t got %b want %b", $time, a, e.o);
      end
`ifdef HAZARD_PERF_EN
      checks += 3;
      if (longint'(hz.perf_load_stalls) != e.ld) begin errors++; $display("FAIL perf_load t=%0t got %0d want %0d", $time, hz.perf_load_stalls, e.ld); end
      if (longint'(hz.perf_branch_stalls) != e.bc) begin errors++; $display("FAIL perf_branch t=%0t got %0d want %0d", $time, hz.perf_branch_stalls, e.bc); end
      if (longint'(hz.perf_mem_wait) != e.mw) begin errors++; $display("FAIL perf_mem t=%0t got %0d want %0d", $time, hz.perf_mem_wait, e.mw); end
`endif
    end
  end
  initial begin
    stim_t s;
    s = '0;
    hz.rs_addr = 0; hz.rt_addr = 0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
    hz.id_is_branch = 0; hz.id_branch_taken = 0; hz.id_ex_MemRead = 0; hz.id_ex_RegWrite = 0;
    hz.id_ex_write_addr = 0; hz.ex_mem_MemRead = 0; hz.ex_mem_write_addr = 0; hz.mem_busy = 0;
    step(s, 0);
    step(s, 0);
    step(s, 1);
    s = '0; s.exr = 1; s.exw = 1; s.exd = 8; s.rs = 8; s.urs = 1; s.rt = 1; s.urt = 1;
    step(s, 1);
    s = '0; s.mr = 1; s.md = 8; s.rs = 9; s.urs = 1;
    step(s, 1);
    s = '0; s.exr = 1; s.exw = 1; s.exd = 8; s.br = 1; s.tk = 1; s.rs = 8; s.urs = 1; s.urt = 1;
    step(s, 1);
    s = '0; s.mr = 1; s.md = 8; s.br = 1; s.tk = 1; s.rs = 8; s.urs = 1; s.urt = 1;
    step(s, 1);
    s = '0; s.br = 1; s.tk = 1; s.rs = 8; s.urs = 1; s.urt = 1;
    step(s, 1);
    s = '0; s.exw = 1; s.exd = 3; s.br = 1; s.rs = 3; s.rt = 4; s.urs = 1; s.urt = 1;
    step(s, 1);
    s = '0; s.exr = 1; s.exw = 1; s.exd = 0; s.urs = 1; s.urt = 1;
    step(s, 1);
    s = '0; s.busy = 1; s.tk = 1;
    repeat (3) step(s, 1);
    s = '0;
    step(s, 1);
    step(s, 1);
    s = '0; s.busy = 1; s.tk = 1;
    step(s, 1);
    step(s, 0);
    s = '0;
    step(s, 1);
    step(s, 1);
    repeat (800) begin
      s.rs = 5'($urandom_range(0, 3)); s.rt = 5'($urandom_range(0, 3));
      s.urs = 1'($urandom); s.urt = 1'($urandom);
      s.br = 1'($urandom); s.tk = 1'($urandom);
      s.exr = 1'($urandom); s.exw = 1'($urandom);
      s.exd = 5'($urandom_range(0, 3));
      s.mr = 1'($urandom); s.md = 5'($urandom_range(0, 3));
      s.busy = $urandom_range(0, 3) == 0;
      step(s, $urandom_range(0, 99) != 0);
    end
    s = '0;
    step(s, 1);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
